// File: rtl/apb4_cmd_master.sv
// APB4 master that turns a valid/ready command into one APB4 transfer
// and returns the outcome (data, slave error, timeout) on a response handshake.
module apb4_cmd_master #(
    parameter int ADDRWIDTH = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                 pclk,
    input  logic                 preset,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_strb,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,

    output logic                 psel,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic                 penable,
    output logic                 pwrite,
    output logic [31:0]          pwdata,
    output logic [3:0]           pstrb,
    input  logic [31:0]          prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Wait-count value seen during the last allowed ACCESS cycle.
    localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       in_access;
    logic       access_done;
    logic       timeout_hit;

    assign accept      = cmd_valid && (state == IDLE);
    assign in_access   = (state == ACCESS);
    assign access_done = in_access && pready;
    assign timeout_hit = (TIMEOUT != 0) && in_access && !pready && (wait_cnt == TO_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred when a case arm leaves state_nxt untouched.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        psel      = (state == SETUP) || (state == ACCESS);
        penable   = (state == ACCESS);
        rsp_valid = (state == RESP);
    end

    // Transfer attributes are captured once at accept and held until the
    // next accept; read transfers carry no data and no byte strobes.
    always_ff @(posedge pclk) begin
        if (preset) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
        end else if (accept) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_write ? cmd_wdata : 32'd0;
            pstrb  <= cmd_write ? cmd_strb : 4'd0;
        end
    end

    // SETUP is the only way into ACCESS, so clearing there starts each
    // transfer's wait count from zero.
    always_ff @(posedge pclk) begin
        if (preset) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (in_access && !pready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Response payload is written only when ACCESS ends and then held
    // through RESP; slave inputs are never looked at outside ACCESS.
    always_ff @(posedge pclk) begin
        if (preset) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (access_done) begin
            rsp_rdata   <= pwrite ? 32'd0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Self-checking bench for apb4_cmd_master: directed scenarios, randomized
// transfers and reset cases, all compared against a transaction-level model.
module tb_apb4_cmd_master;

    localparam int AW = 12;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic [AW-1:0] paddr;
    logic          penable;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    int total = 0;
    int bad   = 0;

    apb4_cmd_master #(.ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .paddr       (paddr),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Slave-side inputs outside ACCESS are random: the master must ignore them.
    task automatic noise();
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
    endtask

    // One complete command, driven from IDLE back to IDLE. 'waits' is the
    // number of ACCESS cycles the slave holds pready low before answering.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int waits, input logic [31:0] rdata,
                           input logic slverr, input int hold);
        logic        timed_out;
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        int          acc;

        timed_out  = (TO != 0) && (waits >= TO);
        exp_acc    = timed_out ? TO : waits + 1;
        exp_rdata  = (timed_out || wr) ? 32'd0 : rdata;
        exp_err    = timed_out ? 1'b1 : slverr;
        exp_pwdata = wr ? wdata : 32'd0;
        exp_pstrb  = wr ? strb : 4'd0;

        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_psel", 32'(psel), 32'd0);

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        noise();
        tick();

        // First cycle after accept: SETUP.
        check("setup_psel", 32'(psel), 32'd1);
        check("setup_penable", 32'(penable), 32'd0);
        check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        check("setup_rsp_valid", 32'(rsp_valid), 32'd0);
        check("setup_paddr", 32'(paddr), 32'(addr));
        check("setup_pwrite", 32'(pwrite), 32'(wr));
        check("setup_pwdata", pwdata, exp_pwdata);
        check("setup_pstrb", 32'(pstrb), 32'(exp_pstrb));

        // A different command offered now must not disturb the transfer.
        cmd_valid = 1'($urandom);
        cmd_write = ~wr;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        cmd_strb  = ~strb;
        noise();
        tick();

        acc = 0;
        while (psel === 1'b1 && penable === 1'b1 && acc < 300) begin
            acc++;
            check("access_paddr", 32'(paddr), 32'(addr));
            check("access_pwdata", pwdata, exp_pwdata);
            check("access_pstrb", 32'(pstrb), 32'(exp_pstrb));
            if (acc == waits + 1) begin
                pready  = 1'b1;
                pslverr = slverr;
                prdata  = rdata;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
            tick();
        end
        check("access_cycles", 32'(acc), 32'(exp_acc));

        cmd_valid = 1'b1;
        noise();
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_psel", 32'(psel), 32'd0);
        check("resp_penable", 32'(penable), 32'd0);
        check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("resp_rdata", rsp_rdata, exp_rdata);
        check("resp_err", 32'(rsp_err), 32'(exp_err));
        check("resp_timeout", 32'(rsp_timeout), 32'(timed_out));

        for (int i = 0; i < hold; i++) begin
            tick();
            noise();
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_err", 32'(rsp_err), 32'(exp_err));
            check("hold_timeout", 32'(rsp_timeout), 32'(timed_out));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_psel", 32'(psel), 32'd0);
        end

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_cmd_ready", 32'(cmd_ready), 32'd1);
        check("done_psel", 32'(psel), 32'd0);
        check("done_paddr_held", 32'(paddr), 32'(addr));
    endtask

    initial begin
        logic        r_wr;
        logic [31:0] r_word;
        int          r_sel;
        int          r_waits;

        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset state, sampled while reset is still asserted.
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_pstrb", 32'(pstrb), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        preset = 1'b0;
        tick();

        // Zero-wait write, slow read, slave error, timeout and its boundary,
        // and a response stalled for five cycles.
        run_txn(1'b1, 12'h0AC, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 0);
        run_txn(1'b0, 12'h010, 32'hA5A5A5A5, 4'h3, 3, 32'h12345678, 1'b0, 0);
        run_txn(1'b0, 12'h020, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b1, 1);
        run_txn(1'b1, 12'h030, 32'h11223344, 4'h5, 16, 32'h0, 1'b0, 0);
        run_txn(1'b0, 12'h034, 32'h0, 4'h0, 15, 32'h87654321, 1'b0, 0);
        run_txn(1'b1, 12'h040, 32'h55AA55AA, 4'hC, 1, 32'h0, 1'b0, 5);

        // Reset while in ACCESS drops the transfer and produces no response.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h3F0;
        pready    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_in_access", 32'(penable), 32'd1);
        tick();
        preset = 1'b1;
        tick();
        preset = 1'b0;
        check("mid_rst_psel", 32'(psel), 32'd0);
        check("mid_rst_penable", 32'(penable), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        pready = 1'b1;
        tick();
        tick();
        check("mid_no_rsp", 32'(rsp_valid), 32'd0);
        check("mid_no_psel", 32'(psel), 32'd0);
        pready = 1'b0;

        // Randomized transfers, including timeout-boundary wait counts.
        for (int n = 0; n < 24; n++) begin
            r_wr   = 1'($urandom);
            r_word = $urandom;
            r_sel  = $urandom_range(0, 9);
            if (r_sel < 7)       r_waits = $urandom_range(0, 3);
            else if (r_sel == 7) r_waits = TO - 1;
            else if (r_sel == 8) r_waits = TO;
            else                 r_waits = TO + 4;
            run_txn(r_wr, 12'($urandom), r_word, 4'($urandom), r_waits,
                    $urandom, 1'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
